// File: rtl/pc_trace_buffer.sv
// Trigger-armed circular trace of the retired PC/write-data stream, drained by a valid/enable pop port.
// Define TRACE_HILO_EN to also record the HI/LO registers alongside each entry.
module pc_trace_buffer #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int POST_CNT = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Arm,
    input  logic [31:0]       Trig_PC,
    input  logic              Cap_Valid,
    input  logic [31:0]       Cap_PC,
    input  logic [31:0]       Cap_Data,
`ifdef TRACE_HILO_EN
    input  logic [31:0]       Cap_Hi,
    input  logic [31:0]       Cap_Lo,
    output logic [31:0]       Rd_Hi,
    output logic [31:0]       Rd_Lo,
`endif
    input  logic              Rd_En,
    output logic              Rd_Valid,
    output logic [31:0]       Rd_PC,
    output logic [31:0]       Rd_Data,
    output logic [ADDR_W:0]   Count,
    output logic [1:0]        State,
    output logic              Triggered
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_CNT);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr, post_cnt;
    logic [ADDR_W:0]     count;
    logic                triggered;
    logic                cap_en, pop_en, trig_fire, rd_valid;

    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_data [DEPTH];
`ifdef TRACE_HILO_EN
    logic [31:0] mem_hi   [DEPTH];
    logic [31:0] mem_lo   [DEPTH];
`endif

    assign rd_valid = (state == FROZEN) && (count != '0);

    always_comb begin
        state_next = state;
        cap_en     = 1'b0;
        pop_en     = 1'b0;
        trig_fire  = 1'b0;
        if (Arm) begin
            state_next = ARMED;
        end else begin
            unique case (state)
                IDLE: state_next = IDLE;
                ARMED: begin
                    if (Cap_Valid) begin
                        cap_en = 1'b1;
                        if (Cap_PC == Trig_PC) begin
                            trig_fire  = 1'b1;
                            state_next = (POST_CNT > 0) ? POST : FROZEN;
                        end
                    end
                end
                POST: begin
                    if (Cap_Valid) begin
                        cap_en = 1'b1;
                        if (post_cnt == ADDR_W'(1)) state_next = FROZEN;
                    end
                end
                FROZEN: pop_en = Rd_En && rd_valid;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
        end else if (Arm) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
        end else begin
            if (cap_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                // When full, the oldest entry is overwritten, so the read pointer follows.
                if (count == FULL) rd_ptr <= rd_ptr + 1'b1;
                else               count  <= count + 1'b1;
            end else if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
            if (trig_fire) begin
                triggered <= 1'b1;
                post_cnt  <= POST_INIT;
            end else if (cap_en && state == POST) begin
                post_cnt <= post_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (cap_en) begin
            mem_pc[wr_ptr]   <= Cap_PC;
            mem_data[wr_ptr] <= Cap_Data;
`ifdef TRACE_HILO_EN
            mem_hi[wr_ptr]   <= Cap_Hi;
            mem_lo[wr_ptr]   <= Cap_Lo;
`endif
        end
    end

    // Read data is gated by valid so it is zero in reset and whenever nothing is poppable.
    assign Rd_PC     = rd_valid ? mem_pc[rd_ptr]   : '0;
    assign Rd_Data   = rd_valid ? mem_data[rd_ptr] : '0;
`ifdef TRACE_HILO_EN
    assign Rd_Hi     = rd_valid ? mem_hi[rd_ptr]   : '0;
    assign Rd_Lo     = rd_valid ? mem_lo[rd_ptr]   : '0;
`endif
    assign Rd_Valid  = rd_valid;
    assign Count     = count;
    assign State     = state;
    assign Triggered = triggered;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed self-checking bench for pc_trace_buffer at DEPTH=16, POST_CNT=8.
module tb_pc_trace_buffer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Arm = 1'b0;
    logic [31:0] Trig_PC = '0;
    logic        Cap_Valid = 1'b0;
    logic [31:0] Cap_PC = '0;
    logic [31:0] Cap_Data = '0;
`ifdef TRACE_HILO_EN
    logic [31:0] Cap_Hi = '0;
    logic [31:0] Cap_Lo = '0;
    logic [31:0] Rd_Hi, Rd_Lo;
`endif
    logic        Rd_En = 1'b0;
    logic        Rd_Valid;
    logic [31:0] Rd_PC, Rd_Data;
    logic [4:0]  Count;
    logic [1:0]  State;
    logic        Triggered;

    int unsigned tests = 0;
    int unsigned fails = 0;

    pc_trace_buffer #(.DEPTH(16), .ADDR_W(4), .POST_CNT(8)) dut (
        .Clk(Clk), .Rst(Rst), .Arm(Arm), .Trig_PC(Trig_PC),
        .Cap_Valid(Cap_Valid), .Cap_PC(Cap_PC), .Cap_Data(Cap_Data),
`ifdef TRACE_HILO_EN
        .Cap_Hi(Cap_Hi), .Cap_Lo(Cap_Lo), .Rd_Hi(Rd_Hi), .Rd_Lo(Rd_Lo),
`endif
        .Rd_En(Rd_En), .Rd_Valid(Rd_Valid), .Rd_PC(Rd_PC), .Rd_Data(Rd_Data),
        .Count(Count), .State(State), .Triggered(Triggered)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic arm(input logic [31:0] tpc);
        Trig_PC = tpc;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    task automatic cap(input logic [31:0] pc, input logic [31:0] data);
        Cap_Valid = 1'b1;
        Cap_PC    = pc;
        Cap_Data  = data;
        tick();
        Cap_Valid = 1'b0;
    endtask

    task automatic pop();
        Rd_En = 1'b1;
        tick();
        Rd_En = 1'b0;
    endtask

    initial begin
        // Reset held for 100ns with inputs toggling
        #1 Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Arm       = 1'($urandom_range(0, 1));
            Cap_Valid = 1'($urandom_range(0, 1));
            Rd_En     = 1'($urandom_range(0, 1));
            Cap_PC    = $urandom;
            Trig_PC   = Cap_PC;
            #10;
            check("rst_state", 64'(State), 64'd0);
            check("rst_count", 64'(Count), 64'd0);
            check("rst_valid", 64'(Rd_Valid), 64'd0);
            check("rst_trig", 64'(Triggered), 64'd0);
            check("rst_rdpc", 64'(Rd_PC), 64'd0);
            check("rst_rddata", 64'(Rd_Data), 64'd0);
        end
        Arm = 1'b0; Cap_Valid = 1'b0; Rd_En = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        tick();
        check("idle_state", 64'(State), 64'd0);

        // Captures in IDLE are ignored
        cap(32'h40, 32'h1);
        check("idle_cap_count", 64'(Count), 64'd0);

        // No trigger
        arm(32'h40);
        check("arm_state", 64'(State), 64'd1);
        for (int i = 0; i < 5; i++) cap(32'(i * 4), 32'(i * 4 + 1));
        pop();
        check("notrig_state", 64'(State), 64'd1);
        check("notrig_count", 64'(Count), 64'd5);
        check("notrig_valid", 64'(Rd_Valid), 64'd0);
        check("notrig_trig", 64'(Triggered), 64'd0);

        // Wrap and freeze
        arm(32'h80);
        check("rearm_count", 64'(Count), 64'd0);
        for (int i = 0; i < 64; i++) begin
            cap(32'(i * 4), 32'(i * 4 + 1));
            if (i == 15) check("wrap_full", 64'(Count), 64'd16);
            if (i == 31) check("wrap_pretrig", 64'(State), 64'd1);
            if (i == 32) begin
                check("wrap_trig_state", 64'(State), 64'd2);
                check("wrap_trig_flag", 64'(Triggered), 64'd1);
            end
            if (i == 39) check("wrap_post_last", 64'(State), 64'd2);
            if (i == 40) check("wrap_frozen", 64'(State), 64'd3);
        end
        check("wrap_count", 64'(Count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check("wrap_rdvalid", 64'(Rd_Valid), 64'd1);
            check("wrap_rdpc", 64'(Rd_PC), 64'(32'h64 + 32'(i * 4)));
            check("wrap_rddata", 64'(Rd_Data), 64'(32'h65 + 32'(i * 4)));
            pop();
        end
        check("wrap_empty_valid", 64'(Rd_Valid), 64'd0);
        check("wrap_empty_count", 64'(Count), 64'd0);

        // Immediate trigger
        arm(32'h0);
        for (int i = 0; i <= 16; i++) cap(32'(i * 4), 32'(i * 4 + 1));
        check("imm_state", 64'(State), 64'd3);
        check("imm_count", 64'(Count), 64'd9);
        for (int i = 0; i < 9; i++) begin
            check("imm_rdpc", 64'(Rd_PC), 64'(i * 4));
            check("imm_rddata", 64'(Rd_Data), 64'(i * 4 + 1));
            pop();
        end
        check("imm_drained", 64'(Count), 64'd0);
        cap(32'h0, 32'h5);
        check("imm_cap_ignored", 64'(Count), 64'd0);
        pop();
        check("imm_pop_empty", 64'(Count), 64'd0);
        check("imm_stay_frozen", 64'(State), 64'd3);
        check("imm_valid_empty", 64'(Rd_Valid), 64'd0);

        // Re-arm mid-POST with a simultaneous capture
        arm(32'h10);
        cap(32'h10, 32'h11);
        for (int i = 1; i <= 3; i++) cap(32'h10 + 32'(i * 4), 32'h0);
        check("mid_state", 64'(State), 64'd2);
        check("mid_count", 64'(Count), 64'd4);
        Arm = 1'b1; Cap_Valid = 1'b1; Cap_PC = 32'h10;
        tick();
        Arm = 1'b0; Cap_Valid = 1'b0;
        check("mid_rearm_state", 64'(State), 64'd1);
        check("mid_rearm_count", 64'(Count), 64'd0);
        check("mid_rearm_trig", 64'(Triggered), 64'd0);

        // Async reset while frozen with 10 entries
        arm(32'h200);
        cap(32'h1FC, 32'h1);
        for (int i = 0; i <= 8; i++) cap(32'h200 + 32'(i * 4), 32'h2);
        check("ar_state", 64'(State), 64'd3);
        check("ar_count", 64'(Count), 64'd10);
        check("ar_rdpc", 64'(Rd_PC), 64'h1FC);
        #3 Rst = 1'b0;
        #1;
        check("ar_rst_state", 64'(State), 64'd0);
        check("ar_rst_count", 64'(Count), 64'd0);
        check("ar_rst_valid", 64'(Rd_Valid), 64'd0);
        check("ar_rst_trig", 64'(Triggered), 64'd0);
        #2 Rst = 1'b1;
        tick();
        check("ar_post_state", 64'(State), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
